// File: rtl/matrix_host_controller.sv
// -----------------------------------------------------------------------------
// matrix_host_controller
//
// Purpose:
//   Accepts 2x2 matrix multiply jobs from a host into a two-entry FIFO and hands
//   them one at a time to an external multiplier over a start / stable / ack
//   handshake. The result is collected with a four-phase ack and held in a
//   one-entry result slot until the host consumes it. A job stuck in SEND or
//   WAIT_C for TIMEOUT_CYCLES cycles is aborted with a one-cycle timeout pulse.
//
// Ports:
//   input_Clk, input_Reset            clock, async active-low reset
//   input_Job_Valid/_A/_B             host job offer (operands {X11,X12,X21,X22})
//   output_Job_Ready                  FIFO has room (from registered count only)
//   output_Start                      one-cycle start pulse to multiplier
//   output_Stable, output_A/_B        operands valid, held until input_AB_Ack
//   input_AB_Ack                      multiplier accepted the operands
//   input_Stable, input_C             multiplier result valid / result data
//   output_C_Ack                      four-phase result acknowledge
//   output_Result_Valid/_Result       captured result to host
//   input_Result_Ready                host consumes result
//   output_Timeout                    one-cycle abort pulse
//   output_Busy                       FSM not in IDLE
// -----------------------------------------------------------------------------
module matrix_host_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         input_Clk,
  input  logic         input_Reset,
  input  logic         input_Job_Valid,
  input  logic [127:0] input_Job_A,
  input  logic [127:0] input_Job_B,
  output logic         output_Job_Ready,
  output logic         output_Start,
  output logic         output_Stable,
  output logic [127:0] output_A,
  output logic [127:0] output_B,
  input  logic         input_AB_Ack,
  input  logic         input_Stable,
  input  logic [127:0] input_C,
  output logic         output_C_Ack,
  output logic         output_Result_Valid,
  output logic [127:0] output_Result,
  input  logic         input_Result_Ready,
  output logic         output_Timeout,
  output logic         output_Busy
);

  // Counter value on the cycle before the limit is reached; the abort takes
  // effect on the edge where the count would become TIMEOUT_CYCLES.
  localparam logic [31:0] TIMEOUT_LAST_C = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_SEND   = 3'd2,
    ST_WAIT_C = 3'd3,
    ST_ACK    = 3'd4
  } state_t;

  state_t        state_r;
  logic [255:0]  fifo_mem_r [2];
  logic          wr_ptr_r;
  logic          rd_ptr_r;
  logic [1:0]    count_r;
  logic [31:0]   cycle_cnt_r;
  logic          start_r;
  logic          stable_r;
  logic          c_ack_r;
  logic          result_valid_r;
  logic          timeout_r;
  logic [127:0]  a_r;
  logic [127:0]  b_r;
  logic [127:0]  result_r;
  logic          push_s;
  logic          pop_s;
  logic [255:0]  head_s;

  // FIFO handshake decode; ready depends on the registered count only, so a
  // full FIFO never accepts a job even when a pop happens the same cycle.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    head_s = fifo_mem_r[rd_ptr_r];
    if (input_Job_Valid && (count_r < 2'd2)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if ((state_r == ST_IDLE) && (count_r != 2'd0) && !result_valid_r) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Two-entry job FIFO storage, pointers and occupancy.
  always_ff @(posedge input_Clk or negedge input_Reset) begin
    if (!input_Reset) begin
      fifo_mem_r[0] <= 256'd0;
      fifo_mem_r[1] <= 256'd0;
      wr_ptr_r      <= 1'b0;
      rd_ptr_r      <= 1'b0;
      count_r       <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {input_Job_A, input_Job_B};
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Job sequencing FSM with all handshake outputs registered.
  always_ff @(posedge input_Clk or negedge input_Reset) begin
    if (!input_Reset) begin
      state_r        <= ST_IDLE;
      cycle_cnt_r    <= 32'd0;
      start_r        <= 1'b0;
      stable_r       <= 1'b0;
      c_ack_r        <= 1'b0;
      result_valid_r <= 1'b0;
      timeout_r      <= 1'b0;
      a_r            <= 128'd0;
      b_r            <= 128'd0;
      result_r       <= 128'd0;
    end else begin
      start_r   <= 1'b0;
      timeout_r <= 1'b0;
      // Host consumption of the result slot; a new capture cannot coincide
      // because IDLE only launches a job once the slot is empty.
      if (result_valid_r && input_Result_Ready) begin
        result_valid_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            a_r     <= head_s[255:128];
            b_r     <= head_s[127:0];
            start_r <= 1'b1;
            state_r <= ST_START;
          end
        end
        ST_START: begin
          stable_r    <= 1'b1;
          cycle_cnt_r <= 32'd0;
          state_r     <= ST_SEND;
        end
        ST_SEND: begin
          // Ack wins over a coincident input_Stable; the result is taken in
          // WAIT_C on the following cycle.
          if (input_AB_Ack) begin
            stable_r    <= 1'b0;
            cycle_cnt_r <= 32'd0;
            state_r     <= ST_WAIT_C;
          end else if (cycle_cnt_r == TIMEOUT_LAST_C) begin
            stable_r    <= 1'b0;
            timeout_r   <= 1'b1;
            cycle_cnt_r <= 32'd0;
            state_r     <= ST_IDLE;
          end else begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
          end
        end
        ST_WAIT_C: begin
          if (input_Stable) begin
            result_r       <= input_C;
            result_valid_r <= 1'b1;
            c_ack_r        <= 1'b1;
            state_r        <= ST_ACK;
          end else if (cycle_cnt_r == TIMEOUT_LAST_C) begin
            timeout_r   <= 1'b1;
            cycle_cnt_r <= 32'd0;
            state_r     <= ST_IDLE;
          end else begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
          end
        end
        ST_ACK: begin
          if (!input_Stable) begin
            c_ack_r <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          stable_r <= 1'b0;
          c_ack_r  <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign output_Job_Ready    = (count_r < 2'd2);
  assign output_Start        = start_r;
  assign output_Stable       = stable_r;
  assign output_A            = a_r;
  assign output_B            = b_r;
  assign output_C_Ack        = c_ack_r;
  assign output_Result_Valid = result_valid_r;
  assign output_Result       = result_r;
  assign output_Timeout      = timeout_r;
  assign output_Busy         = (state_r != ST_IDLE);

endmodule

// File: tb/tb_matrix_host_controller.sv
// -----------------------------------------------------------------------------
// tb_matrix_host_controller
//
// Directed sequence plus randomized jobs for matrix_host_controller with a
// short timeout. Expected results come from a plain 2x2 matrix product of the
// jobs the bench pushed; queue order and FIFO fullness come from a small
// job-queue model.
// -----------------------------------------------------------------------------
module tb_matrix_host_controller;

  localparam int unsigned TO = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         job_valid;
  logic [127:0] job_a;
  logic [127:0] job_b;
  logic         job_ready;
  logic         start;
  logic         stable_o;
  logic [127:0] op_a;
  logic [127:0] op_b;
  logic         ab_ack;
  logic         stable_i;
  logic [127:0] c_in;
  logic         c_ack;
  logic         res_valid;
  logic [127:0] res;
  logic         res_ready;
  logic         timeout;
  logic         busy;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  matrix_host_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .input_Clk           (clk),
    .input_Reset         (rst_n),
    .input_Job_Valid     (job_valid),
    .input_Job_A         (job_a),
    .input_Job_B         (job_b),
    .output_Job_Ready    (job_ready),
    .output_Start        (start),
    .output_Stable       (stable_o),
    .output_A            (op_a),
    .output_B            (op_b),
    .input_AB_Ack        (ab_ack),
    .input_Stable        (stable_i),
    .input_C             (c_in),
    .output_C_Ack        (c_ack),
    .output_Result_Valid (res_valid),
    .output_Result       (res),
    .input_Result_Ready  (res_ready),
    .output_Timeout      (timeout),
    .output_Busy         (busy)
  );

  function automatic logic [127:0] mat_mul(input logic [127:0] a, input logic [127:0] b);
    logic [31:0] a11, a12, a21, a22, b11, b12, b21, b22;
    logic [31:0] c11, c12, c21, c22;
    {a11, a12, a21, a22} = a;
    {b11, b12, b21, b22} = b;
    c11 = a11 * b11 + a12 * b21;
    c12 = a11 * b12 + a12 * b22;
    c21 = a21 * b11 + a22 * b21;
    c22 = a21 * b12 + a22 * b22;
    return {c11, c12, c21, c22};
  endfunction

  function automatic logic [255:0] rand_job();
    logic [255:0] j;
    for (int i = 0; i < 8; i++) j[i*32 +: 32] = $urandom;
    return j;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_job_ready"}, job_ready, 1'b1);
    chk({tag, "_start"}, start, 1'b0);
    chk({tag, "_stable"}, stable_o, 1'b0);
    chk({tag, "_c_ack"}, c_ack, 1'b0);
    chk({tag, "_res_valid"}, res_valid, 1'b0);
    chk({tag, "_timeout"}, timeout, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_op_a"}, op_a, 128'd0);
    chk({tag, "_op_b"}, op_b, 128'd0);
    chk({tag, "_result"}, res, 128'd0);
  endtask

  // Offer one job for one edge; FIFO is expected to have room.
  task automatic push_job(input logic [255:0] j);
    job_valid = 1'b1;
    job_a = j[255:128];
    job_b = j[127:0];
    chk("push_ready", job_ready, 1'b1);
    tick();
    job_valid = 1'b0;
  endtask

  task automatic wait_stable();
    int i;
    i = 0;
    while (stable_o !== 1'b1 && i < 24) begin
      tick();
      i++;
    end
    chk("wait_stable", stable_o, 1'b1);
  endtask

  // Multiplier model: ack after ack_dly held cycles, result after st_dly more
  // (or together with the ack when same is set), then four-phase release.
  task automatic service_job(input logic [255:0] j, input int ack_dly, input bit same, input int st_dly);
    logic [127:0] c;
    c = mat_mul(j[255:128], j[127:0]);
    wait_stable();
    chk("op_a", op_a, j[255:128]);
    chk("op_b", op_b, j[127:0]);
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      chk("hold_stable", stable_o, 1'b1);
      chk("hold_op_a", op_a, j[255:128]);
    end
    ab_ack = 1'b1;
    c_in = c;
    if (same) stable_i = 1'b1;
    tick();
    ab_ack = 1'b0;
    chk("stable_drop", stable_o, 1'b0);
    chk("no_early_result", res_valid, 1'b0);
    if (!same) begin
      for (int i = 0; i < st_dly; i++) begin
        tick();
        chk("wait_c_no_result", res_valid, 1'b0);
      end
      stable_i = 1'b1;
    end
    tick();
    chk("res_valid", res_valid, 1'b1);
    chk("result", res, c);
    chk("c_ack_high", c_ack, 1'b1);
    tick();
    chk("c_ack_held", c_ack, 1'b1);
    stable_i = 1'b0;
    tick();
    chk("c_ack_low", c_ack, 1'b0);
    chk("busy_done", busy, 1'b0);
  endtask

  task automatic consume(input int dly, input logic [127:0] exp_c);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("res_hold_valid", res_valid, 1'b1);
      chk("res_hold_data", res, exp_c);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_consumed", res_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] j;
    logic [255:0] jobs [3];
    logic [255:0] q [$];
    bit           engine_free;
    bit           will_push;
    bit           will_pop;
    int           accepted;
    int           iter;

    rst_n = 1'b0;
    job_valid = 1'b0;
    job_a = 128'd0;
    job_b = 128'd0;
    ab_ack = 1'b0;
    stable_i = 1'b0;
    c_in = 128'd0;
    res_ready = 1'b0;

    // Reset values before any clock edge.
    #2;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Basic flow with exact start/stable latency: identity times {1,2,3,4}.
    j = {32'd1, 32'd0, 32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd4};
    push_job(j);
    chk("lat_start_k", start, 1'b0);
    chk("lat_busy_k", busy, 1'b0);
    tick();
    chk("lat_start_k1", start, 1'b1);
    chk("lat_busy_k1", busy, 1'b1);
    chk("lat_stable_k1", stable_o, 1'b0);
    tick();
    chk("lat_start_k2", start, 1'b0);
    chk("lat_stable_k2", stable_o, 1'b1);
    service_job(j, 2, 1'b0, 1);
    chk("basic_result", res, {32'd1, 32'd2, 32'd3, 32'd4});
    consume(1, {32'd1, 32'd2, 32'd3, 32'd4});

    // Three back-to-back pushes against a job-queue model.
    for (int i = 0; i < 3; i++) jobs[i] = rand_job();
    q = {};
    engine_free = 1'b1;
    accepted = 0;
    iter = 0;
    while (accepted < 3 && iter < 10) begin
      job_valid = 1'b1;
      job_a = jobs[accepted][255:128];
      job_b = jobs[accepted][127:0];
      chk("bp_ready", job_ready, q.size() < 2);
      will_push = q.size() < 2;
      will_pop = engine_free && q.size() > 0;
      tick();
      if (will_pop) begin
        void'(q.pop_front());
        engine_free = 1'b0;
      end
      if (will_push) begin
        q.push_back(jobs[accepted]);
        accepted++;
      end
      iter++;
    end
    job_valid = 1'b0;
    chk("bp_accepted", 128'(accepted), 128'd3);
    chk("bp_full", job_ready, q.size() < 2);
    chk("bp_full_const", job_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      service_job(jobs[i], 3, 1'b0, 2);
      consume(0, mat_mul(jobs[i][255:128], jobs[i][127:0]));
    end

    // Result slot occupied holds the next job in IDLE.
    j = rand_job();
    push_job(j);
    service_job(j, 1, 1'b0, 0);
    jobs[0] = rand_job();
    push_job(jobs[0]);
    for (int i = 0; i < 5; i++) begin
      chk("hold_no_start", start, 1'b0);
      chk("hold_idle", busy, 1'b0);
      tick();
    end
    consume(0, mat_mul(j[255:128], j[127:0]));
    chk("hold_start_not_yet", start, 1'b0);
    tick();
    chk("hold_start_after", start, 1'b1);
    service_job(jobs[0], 0, 1'b0, 0);
    consume(0, mat_mul(jobs[0][255:128], jobs[0][127:0]));

    // Timeout: no ack for the first job, second job follows.
    jobs[0] = rand_job();
    jobs[1] = rand_job();
    push_job(jobs[0]);
    push_job(jobs[1]);
    chk("to_start", start, 1'b1);
    tick();
    chk("to_send", stable_o, 1'b1);
    for (int i = 1; i < int'(TO); i++) begin
      tick();
      chk("to_no_pulse", timeout, 1'b0);
      chk("to_stable", stable_o, 1'b1);
    end
    tick();
    chk("to_pulse", timeout, 1'b1);
    chk("to_stable_drop", stable_o, 1'b0);
    chk("to_idle", busy, 1'b0);
    chk("to_no_result", res_valid, 1'b0);
    tick();
    chk("to_pulse_end", timeout, 1'b0);
    chk("to_next_start", start, 1'b1);
    chk("to_next_op_a", op_a, jobs[1][255:128]);
    service_job(jobs[1], 2, 1'b0, 1);
    consume(0, mat_mul(jobs[1][255:128], jobs[1][127:0]));

    // Ack and input_Stable together.
    j = rand_job();
    push_job(j);
    service_job(j, 1, 1'b1, 0);
    consume(0, mat_mul(j[255:128], j[127:0]));

    // Randomized jobs.
    for (int n = 0; n < 6; n++) begin
      j = rand_job();
      push_job(j);
      service_job(j, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      consume(int'($urandom_range(0, 2)), mat_mul(j[255:128], j[127:0]));
    end

    // Reset pulsed while in ACK with jobs still queued.
    jobs[0] = rand_job();
    jobs[1] = rand_job();
    jobs[2] = rand_job();
    push_job(jobs[0]);
    push_job(jobs[1]);
    push_job(jobs[2]);
    wait_stable();
    ab_ack = 1'b1;
    tick();
    ab_ack = 1'b0;
    stable_i = 1'b1;
    c_in = mat_mul(jobs[0][255:128], jobs[0][127:0]);
    tick();
    chk("rst_in_ack", c_ack, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    stable_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_idle", busy, 1'b0);
      chk("post_rst_no_start", start, 1'b0);
      chk("post_rst_empty", job_ready, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
